// File: rtl/uart_out_buffer.sv
// uart_out_buffer: buffers the SimTop UART0 character stream for the console printer.
// A power-of-two FIFO absorbs the character strobe. It has no backpressure, so any
// character that arrives while the FIFO is full is dropped and counted.
// A three-state flush FSM asks the testbench to flush console output at two points:
// the cycle after a newline leaves the FIFO, and after a run of idle cycles once
// something has been printed.
module uart_out_buffer #(
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned IDLE_TIMEOUT = 1024
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [7:0]               in_ch,
    output logic                     out_valid,
    output logic [7:0]               out_ch,
    input  logic                     out_ready,
    output logic                     flush_req,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              overflow_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [AW:0]   FULL_COUNT   = (AW + 1)'(DEPTH);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(IDLE_TIMEOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(IDLE_TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        PENDING,
        FLUSH
    } state_t;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [TW-1:0] idle_cnt;
    state_t        state;

    logic full;
    logic push;
    logic pop;
    logic drop;
    logic head_is_nl;
    logic timeout_hit;

    // Handshake decode. A pop in the same cycle frees a slot, so a push is still accepted when the FIFO is full.
    always_comb begin
        out_valid   = (count != '0);
        out_ch      = out_valid ? mem[rd_ptr] : '0;
        full        = (count == FULL_COUNT);
        pop         = out_valid && out_ready;
        push        = in_valid && (!full || pop);
        drop        = in_valid && full && !pop;
        head_is_nl  = (out_ch == 8'h0A);
        timeout_hit = (count == '0) && (idle_cnt == TIMEOUT_LAST);
    end

    // Character storage. Reset has no effect here because the pointers and count already invalidate the contents.
    always_ff @(posedge clock) begin
        if (!reset && push) begin
            mem[wr_ptr] <= in_ch;
        end
    end

    // Pointers, occupancy and the saturating drop counter. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (overflow_cnt != '1)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    // Flush FSM with a registered flush_req. The idle timer counts completed empty, pop-free cycles and saturates.
    // A pop takes priority over every other transition, which covers FLUSH->FLUSH and FLUSH->PENDING as well.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            flush_req <= 1'b0;
            idle_cnt  <= '0;
        end else begin
            if (pop || (count != '0)) begin
                idle_cnt <= '0;
            end else if (idle_cnt != TIMEOUT_MAX) begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (pop) begin
                state     <= head_is_nl ? FLUSH : PENDING;
                flush_req <= head_is_nl;
            end else if ((state == PENDING) && timeout_hit) begin
                state     <= FLUSH;
                flush_req <= 1'b1;
            end else if (state == FLUSH) begin
                state     <= IDLE;
                flush_req <= 1'b0;
            end else begin
                flush_req <= 1'b0;
            end
        end
    end

endmodule
